blink_rate_meter: RTL and testbench



---
 rtl/blink_rate_meter.sv | 148 ++++++++++++++
 tb/tb_blink_rate_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_meter.sv
// blink_rate_meter: measures the half-period of an external square wave
// and classifies it as a 1, 2, 5 or 10 Hz blink rate.
// The input is synchronised, both edges are detected, and the clocks
// between consecutive edges are counted. Each completed interval is
// reported with a one-cycle strobe. A stalled input raises a timeout level.
module blink_rate_meter #(
    parameter int          CNT_W        = 25,
    parameter int unsigned HALF_1       = 12500001,
    parameter int unsigned HALF_2       = 6250001,
    parameter int unsigned HALF_5       = 2500001,
    parameter int unsigned HALF_10      = 1250001,
    parameter int unsigned TOL_SHIFT    = 4,
    parameter int unsigned TIMEOUT_CLKS = 25000000
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Sig,
    output logic [CNT_W-1:0] o_Half_Period,
    output logic             o_Valid,
    output logic [2:0]       o_Rate,
    output logic             o_Timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    // Nominal half-periods, listed in rate-code order (code = index + 1).
    localparam int unsigned HALVES [4] = '{HALF_1, HALF_2, HALF_5, HALF_10};

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_reg, s2_reg, s3_reg;
    logic             sig_edge;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [2:0]       rate_reg, rate_next;
    logic             valid_reg, valid_next;
    logic             timeout_reg, timeout_next;
    logic [3:0]       match;
    logic [2:0]       rate_code;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= i_Sig;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // Either polarity of transition counts as an edge.
    assign sig_edge = s2_reg ^ s3_reg;

    // One tolerance window per rate; bounds are fixed at elaboration.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_window
            localparam int unsigned TOL = HALVES[gi] >> TOL_SHIFT;
            localparam logic [CNT_W-1:0] LO = CNT_W'(HALVES[gi] - TOL);
            localparam logic [CNT_W-1:0] HI = CNT_W'(HALVES[gi] + TOL);
            assign match[gi] = (cnt_reg >= LO) && (cnt_reg <= HI);
        end
    endgenerate

    // Windows do not overlap, so the priority order only matters for
    // pathological parameter choices; no match reports code 0.
    always_comb begin
        rate_code = 3'd0;
        if (match[0])      rate_code = 3'd1;
        else if (match[1]) rate_code = 3'd2;
        else if (match[2]) rate_code = 3'd3;
        else if (match[3]) rate_code = 3'd4;
    end

    // State and output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            period_reg  <= '0;
            rate_reg    <= 3'd0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            period_reg  <= period_next;
            rate_reg    <= rate_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic: an edge always takes priority over the timeout,
    // so an interval of exactly TIMEOUT_CLKS is still measured.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        rate_next    = rate_reg;
        valid_next   = 1'b0;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (sig_edge) begin
                    // First edge only starts the interval; nothing to report.
                    state_next   = MEASURE;
                    cnt_next     = ONE;
                    timeout_next = 1'b0;
                end
            end
            MEASURE: begin
                if (sig_edge) begin
                    period_next = cnt_reg;
                    rate_next   = rate_code;
                    valid_next  = 1'b1;
                    cnt_next    = ONE;
                end else if (cnt_reg == TIMEOUT_VAL) begin
                    // Input stalled: keep the last period, drop the rate.
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                    rate_next    = 3'd0;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_Half_Period = period_reg;
    assign o_Rate        = rate_reg;
    assign o_Valid       = valid_reg;
    assign o_Timeout     = timeout_reg;

endmodule

// File: tb/tb_blink_rate_meter.sv
// Directed bench for blink_rate_meter with shortened half-periods.
// Each "window" optionally toggles the input and then watches a fixed number
// of clocks, recording strobes and timeout. A strobe inside a window reports
// the length of the previous window.
module tb_blink_rate_meter;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig;
    logic [CNT_W-1:0] half_period;
    logic             valid;
    logic [2:0]       rate;
    logic             timeout;

    always #5 clk = ~clk;

    blink_rate_meter #(
        .CNT_W        (CNT_W),
        .HALF_1       (1000),
        .HALF_2       (500),
        .HALF_5       (200),
        .HALF_10      (100),
        .TOL_SHIFT    (4),
        .TIMEOUT_CLKS (2000)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Sig         (sig),
        .o_Half_Period (half_period),
        .o_Valid       (valid),
        .o_Rate        (rate),
        .o_Timeout     (timeout)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Window observations.
    int win_strobes;
    int win_k;
    int win_period;
    int win_rate;
    int win_to_k;
    int back_to_back = 0;
    int win_no       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int len, input bit do_toggle);
        bit prev_valid;
        if (do_toggle) sig = ~sig;
        win_strobes = 0;
        win_k       = 0;
        win_period  = 0;
        win_rate    = 0;
        win_to_k    = 0;
        prev_valid  = 1'b0;
        for (int k = 1; k <= len; k++) begin
            step();
            if (valid === 1'b1) begin
                if (prev_valid) back_to_back++;
                win_strobes++;
                if (win_strobes == 1) begin
                    win_k      = k;
                    win_period = int'(half_period);
                    win_rate   = int'(rate);
                end
            end
            prev_valid = (valid === 1'b1);
            if (timeout === 1'b1 && win_to_k == 0) win_to_k = k;
        end
        win_no++;
        $display("[TB] window %0d len=%0d toggle=%0d strobes=%0d at=%0d period=%0d rate=%0d timeout_at=%0d",
                 win_no, len, do_toggle, win_strobes, win_k, win_period, win_rate, win_to_k);
    endtask

    // Checks for a window expected to contain exactly one strobe, 3 clocks
    // after the toggle.
    task automatic check_strobe(input string tag, input int period, input int rt);
        check({tag, "_strobes"}, win_strobes, 1);
        check({tag, "_latency"}, win_k, 3);
        check({tag, "_period"}, win_period, period);
        check({tag, "_rate"}, win_rate, rt);
    endtask

    typedef struct {
        int len;
        int strobes;
        int period;
        int rt;
    } vec_t;

    // Steady 1 Hz, 10 Hz tolerance bounds, then the 2 Hz -> 5 Hz change.
    localparam int NVEC = 12;
    vec_t vecs [NVEC] = '{
        '{1000, 0,    0, 0},   // first edge: no strobe
        '{1000, 1, 1000, 1},
        '{1000, 1, 1000, 1},
        '{ 106, 1, 1000, 1},
        '{ 106, 1,  106, 4},   // upper bound of 10 Hz
        '{  94, 1,  106, 4},
        '{  94, 1,   94, 4},   // lower bound of 10 Hz
        '{ 107, 1,   94, 4},
        '{ 500, 1,  107, 0},   // just outside: strobe with rate 0
        '{ 500, 1,  500, 2},
        '{ 200, 1,  500, 2},
        '{ 200, 1,  200, 3}    // first 200-clock interval is already 5 Hz
    };

    initial begin
        rst = 1'b1;
        sig = 1'b0;
        repeat (3) step();
        check("rst_period", half_period, 0);
        check("rst_valid", valid, 0);
        check("rst_rate", rate, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NVEC; i++) begin
            run_window(vecs[i].len, 1'b1);
            if (vecs[i].strobes == 0) begin
                check($sformatf("v%0d_strobes", i), win_strobes, 0);
            end else begin
                check_strobe($sformatf("v%0d", i), vecs[i].period, vecs[i].rt);
            end
        end

        // Timeout: last edge, then silence. The strobe at k=3 marks the edge;
        // the timeout appears 2000 clocks later.
        run_window(2100, 1'b1);
        check_strobe("to", 200, 3);
        check("to_at", win_to_k, 2003);
        check("to_level", timeout, 1);
        check("to_rate", rate, 0);
        check("to_period_held", half_period, 200);

        // Resume: first edge clears timeout, no strobe.
        run_window(300, 1'b1);
        check("resume_strobes", win_strobes, 0);
        check("resume_timeout", timeout, 0);
        check("resume_period_held", half_period, 200);

        // Next edge strobes; this window is exactly the timeout count long.
        run_window(2000, 1'b1);
        check_strobe("resume2", 300, 0);
        check("resume2_no_to", win_to_k, 0);

        // Edge lands on the cycle where cnt == 2000: edge wins.
        run_window(500, 1'b1);
        check_strobe("edge_at_to", 2000, 0);
        check("edge_at_to_no_to", win_to_k, 0);

        // Reset 50 clocks after an edge, with the input high.
        run_window(50, 1'b1);
        check_strobe("pre_rst", 500, 2);
        check("pre_rst_sig", sig, 1);
        rst = 1'b1;
        step();
        check("mid_rst_period", half_period, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_rate", rate, 0);
        check("mid_rst_timeout", timeout, 0);
        rst = 1'b0;

        // Spurious edge from the cleared history flop: treated as first edge.
        run_window(300, 1'b0);
        check("spurious_strobes", win_strobes, 0);
        check("spurious_no_to", win_to_k, 0);

        // First real toggle closes the interval begun by the spurious edge;
        // only the following real edge reflects the true input period.
        run_window(400, 1'b1);
        check("real1_no_to", win_to_k, 0);
        run_window(100, 1'b1);
        check_strobe("real2", 400, 0);

        check("no_back_to_back", back_to_back, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
